// File: rtl/morse_receiver_if.sv
// -----------------------------------------------------------------------------
// morse_receiver_if
// Groups the Morse receiver's serial input strobe and its decode-result
// outputs into one bundle.
//   DotDashIn   : serial Morse unit (1 = tone, 0 = gap)
//   NewBitIn    : one-cycle strobe, DotDashIn valid in that cycle
//   Letter      : decoded letter index (A = 0 ... H = 7)
//   LetterValid : one-cycle pulse, new decode result present
//   CodeError   : qualified by LetterValid, pattern matched no table entry
//   Busy        : receiver is collecting or decoding a letter
//   Timeout     : one-cycle pulse, only when MORSE_RX_TIMEOUT_EN is defined
// Modports: master = the unit producing the strobes and consuming results,
//           slave  = the receiver itself.
// Optional feature macro: MORSE_RX_TIMEOUT_EN (adds the Timeout signal).
// -----------------------------------------------------------------------------
interface morse_receiver_if;
  logic       DotDashIn;
  logic       NewBitIn;
  logic [2:0] Letter;
  logic       LetterValid;
  logic       CodeError;
  logic       Busy;
`ifdef MORSE_RX_TIMEOUT_EN
  logic       Timeout;

  modport master (
    output DotDashIn, NewBitIn,
    input  Letter, LetterValid, CodeError, Busy, Timeout
  );
  modport slave (
    input  DotDashIn, NewBitIn,
    output Letter, LetterValid, CodeError, Busy, Timeout
  );
`else
  modport master (
    output DotDashIn, NewBitIn,
    input  Letter, LetterValid, CodeError, Busy
  );
  modport slave (
    input  DotDashIn, NewBitIn,
    output Letter, LetterValid, CodeError, Busy
  );
`endif
endinterface

// File: rtl/morse_receiver.sv
// -----------------------------------------------------------------------------
// morse_receiver
// Collects a serial Morse letter (one unit per NewBitIn strobe), terminates
// it on a run of three gap units or after twelve units, left-justifies the
// pattern and matches it against the eight-entry A..H table.
// Ports:
//   clock  : system clock, rising-edge active
//   Reset  : asynchronous, active-high reset
//   bus    : morse_receiver_if.slave (DotDashIn/NewBitIn in; Letter,
//            LetterValid, CodeError, Busy [, Timeout] out)
// Parameter:
//   CLOCK_FREQUENCY : clock cycles per second, used only by the timeout.
// Optional feature macro: MORSE_RX_TIMEOUT_EN -- aborts a letter after 2 s
// in COLLECT without a strobe and pulses Timeout.
// -----------------------------------------------------------------------------
module morse_receiver #(
  parameter int CLOCK_FREQUENCY = 50000000
) (
  input  logic           clock,
  input  logic           Reset,
  morse_receiver_if.slave bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DECODE  = 2'd2;
  localparam logic [1:0] S_OUT     = 2'd3;

  // Entry gi is the left-justified pattern of letter index gi (A first).
  localparam logic [7:0][11:0] CODE_TABLE = {
    12'b101010100000,  // H
    12'b111011101000,  // G
    12'b101011101000,  // F
    12'b100000000000,  // E
    12'b111010100000,  // D
    12'b111010111010,  // C
    12'b111010101000,  // B
    12'b101110000000   // A
  };

  // Elaboration-time sanity check on the clock rate.
  if (CLOCK_FREQUENCY < 1) begin : g_bad_clock_frequency
    $error("CLOCK_FREQUENCY must be positive");
  end

  logic [1:0]  state_q, state_d;
  logic [11:0] sr_q, sr_d;
  logic [3:0]  n_q, n_d;
  logic [1:0]  z_q, z_d;
  logic [2:0]  letter_q, letter_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  // Left-justify the collected units; the marker-free SR holds exactly N bits.
  logic [11:0] pattern;
  logic [7:0]  hit;
  logic [2:0]  hit_idx;

  assign pattern = sr_q << (4'd12 - n_q);

  for (genvar gi = 0; gi < 8; gi++) begin : g_match
    assign hit[gi] = (pattern == CODE_TABLE[gi]);
  end

  // Table entries are distinct, so at most one bit of hit is set.
  always_comb begin
    hit_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (hit[i]) hit_idx = 3'(i);
    end
  end

`ifdef MORSE_RX_TIMEOUT_EN
  localparam int CW = (CLOCK_FREQUENCY > 0) ? $clog2(2 * CLOCK_FREQUENCY) : 1;
  localparam logic [CW-1:0] TO_LIMIT = CW'(2 * CLOCK_FREQUENCY - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc     = cnt_q + CW'(1);
  assign bus.Timeout = timeout_q;
`endif

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    n_d      = n_q;
    z_d      = z_q;
    letter_d = letter_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
`ifdef MORSE_RX_TIMEOUT_EN
    cnt_d     = '0;
    timeout_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        // A gap strobe on an idle line is not the start of a letter.
        if (bus.NewBitIn && bus.DotDashIn) begin
          sr_d    = 12'd1;
          n_d     = 4'd1;
          z_d     = 2'd0;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (bus.NewBitIn) begin
          sr_d = {sr_q[10:0], bus.DotDashIn};
          n_d  = n_q + 4'd1;
          if (bus.DotDashIn) z_d = 2'd0;
          else               z_d = (z_q == 2'd3) ? 2'd3 : z_q + 2'd1;
          if (z_d == 2'd3 || n_d == 4'd12) state_d = S_DECODE;
        end
`ifdef MORSE_RX_TIMEOUT_EN
        else if (cnt_inc == TO_LIMIT) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end
      S_DECODE: begin
        // Result registers load here so LetterValid is high during OUT.
        valid_d = 1'b1;
        if (|hit) letter_d = hit_idx;
        else      err_d    = 1'b1;
        state_d = S_OUT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      sr_q     <= 12'd0;
      n_q      <= 4'd0;
      z_q      <= 2'd0;
      letter_q <= 3'd0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef MORSE_RX_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      n_q      <= n_d;
      z_q      <= z_d;
      letter_q <= letter_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
`ifdef MORSE_RX_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus.Letter      = letter_q;
  assign bus.LetterValid = valid_q;
  assign bus.CodeError   = err_q;
  assign bus.Busy        = (state_q == S_COLLECT) || (state_q == S_DECODE);

endmodule

// File: tb/tb_morse_receiver.sv
module tb_morse_receiver;
`ifdef MORSE_RX_TIMEOUT_EN
  localparam int CLK_FREQ = 4;
`else
  localparam int CLK_FREQ = 50000000;
`endif

  logic clock = 1'b0;
  logic Reset = 1'b1;
  always #5 clock = ~clock;

  morse_receiver_if bus_if();

  morse_receiver #(.CLOCK_FREQUENCY(CLK_FREQ)) dut (
    .clock (clock),
    .Reset (Reset),
    .bus   (bus_if)
  );

  typedef struct {
    logic [11:0] bits;   // right-justified units, first unit is bits[n-1]
    int          n;
    logic [2:0]  letter;
    logic        err;
    int          lead_zeros;
  } vec_t;

  typedef struct {
    logic [2:0] letter;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  logic [2:0] held_letter = 3'd0;
  vec_t       vecs[12];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Result monitor: every LetterValid pulse must match the oldest pending
  // expectation, including its arrival cycle.
  always @(negedge clock) begin
    if (!Reset) begin
      if (bus_if.LetterValid === 1'b1) begin
        if (sb.size() == 0) begin
          check("spurious LetterValid", sb.size(), 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("Letter", int'(bus_if.Letter), int'(e.letter));
          check("CodeError", int'(bus_if.CodeError), int'(e.err));
          check("latency", cyc, e.cyc);
          $display("decode: Letter=%0d CodeError=%0d at cycle %0d", bus_if.Letter, bus_if.CodeError, cyc);
        end
      end else if (bus_if.CodeError !== 1'b0) begin
        check("CodeError without LetterValid", int'(bus_if.CodeError), 0);
      end
    end
  end

  task automatic idle(input int k);
    if (k > 0) begin
      repeat (k) @(posedge clock);
      #1;
    end
  endtask

  task automatic strobe(input logic b);
    bus_if.NewBitIn  = 1'b1;
    bus_if.DotDashIn = b;
    @(posedge clock);
    #1;
    bus_if.NewBitIn  = 1'b0;
    bus_if.DotDashIn = 1'b0;
  endtask

  // Push the expectation for a letter whose terminating strobe just landed.
  task automatic expect_letter(input logic [2:0] letter, input logic err);
    exp_t e;
    e.letter = err ? held_letter : letter;
    e.err    = err;
    e.cyc    = cyc + 1;
    held_letter = e.letter;
    sb.push_back(e);
  endtask

  task automatic send(input vec_t v, input int tail);
    for (int i = 0; i < v.lead_zeros; i++) strobe(1'b0);
    for (int i = 0; i < v.n; i++) begin
      strobe(v.bits[v.n-1-i]);
      if (i < v.n - 1) idle(int'($urandom_range(0, 2)));
    end
    expect_letter(v.letter, v.err);
    idle(tail);
  endtask

  initial begin
    vec_t h_vec;
    vec_t e_vec;
    bus_if.NewBitIn  = 1'b0;
    bus_if.DotDashIn = 1'b0;

    vecs[0]  = '{12'b000010111000,  8, 3'd0, 1'b0, 0};  // A
    vecs[1]  = '{12'b111010101000, 12, 3'd1, 1'b0, 0};  // B
    vecs[2]  = '{12'b111010111010, 12, 3'd2, 1'b0, 2};  // C after idle zeros
    vecs[3]  = '{12'b001110101000, 10, 3'd3, 1'b0, 0};  // D
    vecs[4]  = '{12'b101011101000, 12, 3'd5, 1'b0, 0};  // F
    vecs[5]  = '{12'b111011101000, 12, 3'd6, 1'b0, 0};  // G
    vecs[6]  = '{12'b001010101000, 10, 3'd7, 1'b0, 0};  // H
    vecs[7]  = '{12'b000000001000,  4, 3'd4, 1'b0, 0};  // E
    vecs[8]  = '{12'b000011111000,  8, 3'd0, 1'b1, 0};  // no match, Letter holds E
    vecs[9]  = '{12'b111111111111, 12, 3'd0, 1'b1, 0};  // no match at 12 units
    vecs[10] = '{12'b000010111000,  8, 3'd0, 1'b0, 1};  // A after one idle zero
    vecs[11] = '{12'b000000001000,  4, 3'd4, 1'b0, 0};  // E

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("reset Letter", int'(bus_if.Letter), 0);
    check("reset LetterValid", int'(bus_if.LetterValid), 0);
    check("reset CodeError", int'(bus_if.CodeError), 0);
    check("reset Busy", int'(bus_if.Busy), 0);
    Reset = 1'b0;
    idle(2);

    foreach (vecs[i]) begin
      send(vecs[i], 4);
      check("Busy after decode", int'(bus_if.Busy), 0);
    end

    // Reset mid-letter discards the partial B/D and clears the held letter.
    strobe(1'b1); strobe(1'b1); strobe(1'b1); strobe(1'b0);
    check("Busy mid-letter", int'(bus_if.Busy), 1);
    #2 Reset = 1'b1;
    #1;
    check("async reset Busy", int'(bus_if.Busy), 0);
    check("async reset Letter", int'(bus_if.Letter), 0);
    held_letter = 3'd0;
    @(posedge clock);
    #2 Reset = 1'b0;
    idle(1);
    e_vec = '{12'b000000001000, 4, 3'd4, 1'b0, 0};
    send(e_vec, 4);
    check("Busy after post-reset E", int'(bus_if.Busy), 0);

    // Strobes landing in DECODE and OUT are dropped; H still decodes cleanly.
    strobe(1'b1); strobe(1'b0); strobe(1'b0); strobe(1'b0);
    expect_letter(3'd4, 1'b0);
    strobe(1'b1);  // DECODE cycle
    strobe(1'b1);  // OUT cycle
    check("Busy after dropped strobes", int'(bus_if.Busy), 0);
    idle(2);
    h_vec = '{12'b001010101000, 10, 3'd7, 1'b0, 0};
    send(h_vec, 4);

`ifdef MORSE_RX_TIMEOUT_EN
    begin
      int c0;
      int seen;
      strobe(1'b1);
      c0 = cyc;
      seen = -1;
      for (int i = 0; i < 20 && seen < 0; i++) begin
        @(negedge clock);
        if (bus_if.Timeout === 1'b1) seen = cyc;
      end
      check("Timeout cycle", seen, c0 + 7);
      @(negedge clock);
      check("Timeout width", int'(bus_if.Timeout), 0);
      check("Busy after Timeout", int'(bus_if.Busy), 0);
      idle(2);
      send(vecs[0], 4);
    end
`endif

    // Drain: every expected decode must have been seen.
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clock);
    #1;
    check("pending decodes", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/morse_receiver.md
MORSE_RECEIVER -- requirements
Module: morse_receiver

Interface
REQ-001 Parameter: CLOCK_FREQUENCY, default 50000000, clock cycles per second; used only by the timeout feature.
REQ-002 Port: clock  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: Reset  input  1  asynchronous, active-high reset.
REQ-004 Port: DotDashIn  input  1  serial Morse unit value (1 = tone, 0 = gap), from the upstream encoder.
REQ-005 Port: NewBitIn  input  1  one-cycle strobe; DotDashIn is valid in that cycle.
REQ-006 Port: Letter  output  3  decoded letter (000 = A ... 111 = H); held until the next decode.
REQ-007 Port: LetterValid  output  1  one-cycle pulse; a new decode result is present.
REQ-008 Port: CodeError  output  1  qualified by LetterValid; the pattern matched no entry in the table.
REQ-009 Port: Busy  output  1  high while in COLLECT or DECODE.
REQ-010 Port: Timeout  output  1  present only when MORSE_RX_TIMEOUT_EN is defined; one-cycle pulse.

Function
REQ-011 States: IDLE, COLLECT, DECODE, OUT; one-hot or binary encoding is allowed.
REQ-012 IDLE: NewBitIn with DotDashIn=0 is ignored (line idle).
- NewBitIn with DotDashIn=1 loads shift register SR[11:0] = 12'b1 and bit count N = 1.
- Clears zero-run count Z and moves to COLLECT.
REQ-013 COLLECT: each NewBitIn shifts DotDashIn into SR LSB and increments N.
- Z is cleared on a 1 and incremented on a 0.
- Cycles without NewBitIn leave SR, N and Z unchanged.
REQ-014 Termination occurs on the strobe that makes Z==3 or N==12, whichever comes first; the next state is DECODE.
REQ-015 DECODE (one cycle): compute pattern P = SR << (12-N), i.e. left-justified with zero padding.
- Compare P against the table:
  - A 101110000000
  - B 111010101000
  - C 111010111010
  - D 111010100000
  - E 100000000000
  - F 101011101000
  - G 111011101000
  - H 101010100000
REQ-016 OUT (one cycle): LetterValid=1.
- On a match: Letter = index, CodeError = 0.
- No match: Letter unchanged, CodeError = 1.
- Next state is IDLE.
REQ-017 Latency: LetterValid rises exactly 2 clock cycles after the terminating NewBitIn cycle.
REQ-018 NewBitIn in the DECODE or OUT cycle is dropped; its bit is lost.
REQ-019 N is 4 bits, Z is 2 bits; Z saturates at 3, and N never exceeds 12.
REQ-020 Outputs are registered; LetterValid and CodeError are low in all states except OUT.

Reset
REQ-021 Reset forces state to IDLE immediately, regardless of state or clock.
- SR, N and Z are set to 0.
- Letter, LetterValid, CodeError and Timeout are set to 0.
REQ-022 Reset asserted mid-letter discards the partial letter; no LetterValid is produced for it.

Configuration
REQ-023 Macro MORSE_RX_TIMEOUT_EN defined: a cycle counter runs in COLLECT and clears on every NewBitIn.
- When the counter reaches CLOCK_FREQUENCY*2 - 1 (2 s with no strobe), Timeout pulses for one cycle.
- The block then returns to IDLE without asserting LetterValid.
REQ-024 Macro not defined: no counter and no Timeout port; COLLECT waits indefinitely.

Verification
REQ-025 Strobes carrying 1,0,1,1,1,0,0,0 -> LetterValid one pulse 2 cycles after the last strobe, Letter=000, CodeError=0.
REQ-026 Strobes 0,0 (idle), then 111010111010 (12 bits) -> Letter=010 (C) at the 12th-bit termination; no extra decode from the leading zeros.
REQ-027 Strobes 1,0,0,0 -> Letter=100 (E); then 1,1,1,1,1,0,0,0 -> LetterValid with CodeError=1 and Letter still 100.
REQ-028 Reset pulsed after strobes 1,1,1,0 then 1,0,0,0 sent -> Letter=100 (E), no B/D result, Busy low after decode.
REQ-029 MORSE_RX_TIMEOUT_EN with CLOCK_FREQUENCY=4: strobe 1 then no strobes -> Timeout pulses 8 cycles later, state IDLE, no LetterValid.
REQ-030 Strobe asserted during the DECODE cycle -> bit dropped; the following letter 1,0,1,0,1,0,1,0,0,0 decodes as H (111).
